// File: rtl/quad_count_sequencer_pkg.sv
// Shared types and elaboration-time helpers for the quadruple-count sequencer.
package quad_count_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Number of index quadruples a<b<c<d over n entries, C(n,4).
    function automatic int nquad(input int n);
        return (n * (n - 1) * (n - 2) * (n - 3)) / 24;
    endfunction

    // Width of an array index / load pointer.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Four W-bit unsigned elements never overflow W+2 bits.
    function automatic int sum_w(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/quad_count_sequencer_if.sv
// Host-side bundle: job control, element stream in, result handshake out.
interface quad_count_sequencer_if #(
    parameter int W  = 8,
    parameter int CW = 16
);
    logic          start;
    logic [W+1:0]  target;
    logic          abort;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic          out_saturated;

    modport master (
        output start, target, abort, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_count, out_saturated
    );

    modport slave (
        input  start, target, abort, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_count, out_saturated
    );
endinterface

// File: rtl/quad_count_sequencer_walker.sv
// Lexicographic walker over index quadruples a<b<c<d, starting at (0,1,2,3).
module quad_index_walker
    import quad_count_sequencer_pkg::*;
#(
    parameter int N = 8,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          step,
    output logic [IW-1:0] idx_a,
    output logic [IW-1:0] idx_b,
    output logic [IW-1:0] idx_c,
    output logic [IW-1:0] idx_d,
    output logic          last
);

    localparam logic [IW-1:0] ONE   = IW'(1);
    localparam logic [IW-1:0] MAX_A = IW'(N - 4);
    localparam logic [IW-1:0] MAX_B = IW'(N - 3);
    localparam logic [IW-1:0] MAX_C = IW'(N - 2);
    localparam logic [IW-1:0] MAX_D = IW'(N - 1);

    // a reaching N-4 forces b,c,d to their maxima, so it alone marks the end.
    assign last = (idx_a == MAX_A);

    // Advance the innermost index that still has room, re-packing the ones inside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            idx_a <= IW'(0);
            idx_b <= IW'(1);
            idx_c <= IW'(2);
            idx_d <= IW'(3);
        end else if (step && !last) begin
            if (idx_d != MAX_D) begin
                idx_d <= idx_d + ONE;
            end else if (idx_c != MAX_C) begin
                idx_c <= idx_c + ONE;
                idx_d <= idx_c + ONE + ONE;
            end else if (idx_b != MAX_B) begin
                idx_b <= idx_b + ONE;
                idx_c <= idx_b + ONE + ONE;
                idx_d <= idx_b + ONE + ONE + ONE;
            end else begin
                idx_a <= idx_a + ONE;
                idx_b <= idx_a + ONE + ONE;
                idx_c <= idx_a + ONE + ONE + ONE;
                idx_d <= idx_a + ONE + ONE + ONE + ONE;
            end
        end
    end

endmodule

// File: rtl/quad_count_sequencer.sv
// Sequential quadruple counter: load N elements, visit every a<b<c<d once,
// count quadruples whose element sum equals the target, present the count.
module quad_count_sequencer
    import quad_count_sequencer_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    quad_count_sequencer_if.slave bus
);

    localparam int IW = idx_w(N);
    localparam int SW = sum_w(W);
    localparam logic [IW-1:0] PTR_LAST = IW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    if (N < 4) begin : g_bad_n
        $error("quad_count_sequencer: N must be at least 4");
    end

    state_t        state_q, state_d;
    logic [W-1:0]  mem [N];
    logic [IW-1:0] ptr_q;
    logic [SW-1:0] target_q;
    logic [IW-1:0] idx_a, idx_b, idx_c, idx_d;
    logic          last;
    logic [SW-1:0] sum_c;
    logic          match_p0;
    logic          vld_p0;
    logic [CW-1:0] cnt_q;
    logic          sat_q;
    logic          start_acc, beat_acc, do_abort;

    // Widened four-way sum; W+2 bits cannot overflow.
    function automatic logic [SW-1:0] add4(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                           input logic [W-1:0] x2, input logic [W-1:0] x3);
        return SW'(x0) + SW'(x1) + SW'(x2) + SW'(x3);
    endfunction

    // Saturating increment: returns {saturated, count}; sticks at all-ones.
    function automatic logic [CW:0] sat_inc(input logic [CW-1:0] c, input logic s);
        if (c == CNT_MAX) return {1'b1, c};
        else              return {s, c + CW'(1)};
    endfunction

    assign start_acc = (state_q == ST_IDLE) && bus.start;
    assign do_abort  = (state_q != ST_IDLE) && bus.abort;
    assign beat_acc  = (state_q == ST_LOAD) && bus.in_valid;

    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.in_ready      = (state_q == ST_LOAD);
    assign bus.out_valid     = (state_q == ST_DONE);
    assign bus.out_count     = cnt_q;
    assign bus.out_saturated = sat_q;

    quad_index_walker #(.N(N)) u_walker (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != ST_SCAN),
        .step  (state_q == ST_SCAN),
        .idx_a (idx_a),
        .idx_b (idx_b),
        .idx_c (idx_c),
        .idx_d (idx_d),
        .last  (last)
    );

    assign sum_c = add4(mem[idx_a], mem[idx_b], mem[idx_c], mem[idx_d]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_LOAD;
            ST_LOAD:  if (beat_acc && ptr_q == PTR_LAST) state_d = ST_SCAN;
            ST_SCAN:  if (last) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (do_abort) state_d = ST_IDLE;
    end

    // Load pointer and target capture; target only moves on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            target_q <= '0;
        end else if (start_acc) begin
            ptr_q    <= '0;
            target_q <= bus.target;
        end else if (beat_acc && ptr_q != PTR_LAST) begin
            ptr_q <= ptr_q + IW'(1);
        end
    end

    // Element storage and stage-0 compare (data path, not reset).
    always_ff @(posedge clk) begin
        if (beat_acc) mem[ptr_q] <= bus.in_data;
        match_p0 <= (sum_c == target_q);
    end

    // Stage 1: accumulate registered matches; this lag is what the DRAIN state covers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            vld_p0 <= (state_q == ST_SCAN) && !bus.abort;
            if (do_abort || start_acc) begin
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else if (vld_p0 && match_p0) begin
                {sat_q, cnt_q} <= sat_inc(cnt_q, sat_q);
            end
        end
    end

endmodule

// File: tb/tb_quad_count_sequencer.sv
// Randomised bench for quad_count_sequencer with a queue-based scoreboard.
// Two instances (CW=16 and CW=6) share one stimulus stream.
`timescale 1ns/1ps
module tb_quad_count_sequencer;

    localparam int N = 8;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    quad_count_sequencer_if #(.W(W), .CW(16)) bus16();
    quad_count_sequencer_if #(.W(W), .CW(6))  bus6();

    assign bus6.start     = bus16.start;
    assign bus6.target    = bus16.target;
    assign bus6.abort     = bus16.abort;
    assign bus6.in_valid  = bus16.in_valid;
    assign bus6.in_data   = bus16.in_data;
    assign bus6.out_ready = bus16.out_ready;

    quad_count_sequencer #(.N(N), .W(W), .CW(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    quad_count_sequencer #(.N(N), .W(W), .CW(6))  dut6  (.clk(clk), .rst_n(rst_n), .bus(bus6));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int count;
        int vcyc;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] el [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: brute-force enumeration of index quadruples.
    function automatic void model(input int tgt, output int cnt, output int nq);
        cnt = 0;
        nq  = 0;
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++)
                for (int c = b + 1; c < N; c++)
                    for (int d = c + 1; d < N; d++) begin
                        nq++;
                        if (int'(el[a]) + int'(el[b]) + int'(el[c]) + int'(el[d]) == tgt) cnt++;
                    end
    endfunction

    // Monitor: pops an expectation when out_valid rises, checks it every cycle until handshake.
    exp_t cur;
    bit   have = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            have = 0;
        end else begin
            if (bus16.out_valid && !have) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1;
                    chk("latency", 64'(cyc), 64'(cur.vcyc));
                end
            end
            if (have) begin
                chk("out_valid_held", 64'(bus16.out_valid), 64'd1);
                chk("count16", 64'(bus16.out_count), 64'(cur.count));
                chk("sat16", 64'(bus16.out_saturated), 64'd0);
                chk("valid6", 64'(bus6.out_valid), 64'd1);
                chk("count6", 64'(bus6.out_count), 64'((cur.count > 63) ? 63 : cur.count));
                chk("sat6", 64'(bus6.out_saturated), 64'((cur.count > 63) ? 1 : 0));
                if (bus16.out_valid && bus16.out_ready) have = 0;
            end
        end
    end

    // One job: start, stream el[], then either abort in SCAN or collect the result.
    task automatic run_job(input int tgt, input int abort_at, input int hold, input bit poke);
        int k, guard, cnt, nq, t_last;
        t_last = 0;
        @(posedge clk); #1;
        bus16.start  = 1'b1;
        bus16.target = 10'(tgt);
        @(negedge clk);
        chk("idle_busy", 64'(bus16.busy), 64'd0);
        @(posedge clk); #1;
        bus16.start = 1'b0;
        chk("load_in_ready", 64'(bus16.in_ready), 64'd1);
        chk("load_count_cleared", 64'(bus16.out_count), 64'd0);
        k = 0;
        guard = 0;
        while (k < N && guard < 200) begin
            @(posedge clk); #1;
            guard++;
            bus16.in_valid = ($urandom_range(0, 3) != 0);
            bus16.in_data  = el[k];
            if (poke && k == 2) begin
                bus16.start  = 1'b1;
                bus16.target = 10'(tgt + 1);
            end else begin
                bus16.start = 1'b0;
            end
            @(negedge clk);
            if (bus16.in_valid && bus16.in_ready) begin
                if (k == N - 1) t_last = cyc;
                k++;
            end
        end
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        bus16.start    = 1'b0;
        if (k < N) begin
            chk("load_timeout", 64'(k), 64'(N));
            return;
        end
        model(tgt, cnt, nq);
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(posedge clk);
            #1;
            bus16.abort = 1'b1;
            @(negedge clk);
            chk("scan_busy", 64'(bus16.busy), 64'd1);
            @(posedge clk); #1;
            bus16.abort = 1'b0;
            chk("abort_busy", 64'(bus16.busy), 64'd0);
            chk("abort_out_valid", 64'(bus16.out_valid), 64'd0);
            chk("abort_count", 64'(bus16.out_count), 64'd0);
            repeat (100) @(posedge clk);
            #1;
            return;
        end
        exp_q.push_back('{count: cnt, vcyc: t_last + nq + 2});
        guard = 0;
        while (!bus16.out_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus16.out_valid) begin
            chk("result_timeout", 64'(bus16.out_valid), 64'd1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bus16.start  = poke && (i == 1);
            bus16.target = 10'(tgt + 3);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus16.start     = 1'b0;
        bus16.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        chk("post_hs_valid", 64'(bus16.out_valid), 64'd0);
        chk("post_hs_busy", 64'(bus16.busy), 64'd0);
        chk("post_hs_count_kept", 64'(bus16.out_count), 64'(cnt));
    endtask

    function automatic void fill_const(input int v);
        for (int i = 0; i < N; i++) el[i] = 8'(v);
    endfunction

    function automatic void fill_ramp();
        for (int i = 0; i < N; i++) el[i] = 8'(i + 1);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt, qa, qb, qc, qd, maxv;
        bus16.start     = 1'b0;
        bus16.target    = '0;
        bus16.abort     = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.in_data   = '0;
        bus16.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus16.busy), 64'd0);
        chk("rst_in_ready", 64'(bus16.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus16.out_valid), 64'd0);
        chk("rst_out_count", 64'(bus16.out_count), 64'd0);
        chk("rst_out_sat", 64'(bus16.out_saturated), 64'd0);
        chk("rst_busy6", 64'(bus6.busy), 64'd0);
        rst_n = 1'b1;

        // All zeros: every quadruple matches; saturates the narrow counter.
        fill_const(0);
        run_job(0, 0, 0, 0);
        // Ramp 1..8: single extremes and an unreachable target.
        fill_ramp();
        run_job(10, 0, 1, 0);
        run_job(26, 0, 0, 0);
        run_job(9, 0, 2, 0);
        // Full-scale elements exercise the widened sum.
        fill_const(255);
        run_job(1020, 0, 0, 0);
        run_job(1019, 0, 0, 0);
        // Abort mid-scan, then a clean job.
        fill_ramp();
        run_job(10, 30, 0, 0);
        run_job(10, 0, 0, 0);
        // Stalled result with start pulses during LOAD and DONE.
        fill_ramp();
        run_job(18, 0, 5, 1);

        // Random jobs.
        for (int j = 0; j < 10; j++) begin
            maxv = ($urandom_range(0, 1) != 0) ? 3 : 255;
            for (int i = 0; i < N; i++) el[i] = 8'($urandom_range(0, maxv));
            qa = $urandom_range(0, 4);
            qb = $urandom_range(qa + 1, 5);
            qc = $urandom_range(qb + 1, 6);
            qd = $urandom_range(qc + 1, 7);
            tgt = ($urandom_range(0, 3) != 0)
                ? int'(el[qa]) + int'(el[qb]) + int'(el[qc]) + int'(el[qd])
                : int'($urandom_range(0, 1020));
            run_job(tgt, 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a load.
        @(posedge clk); #1;
        bus16.start  = 1'b1;
        bus16.target = '0;
        @(posedge clk); #1;
        bus16.start    = 1'b0;
        bus16.in_valid = 1'b1;
        bus16.in_data  = 8'd5;
        repeat (3) @(posedge clk);
        #3;
        chk("midload_busy", 64'(bus16.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(bus16.in_ready), 64'd0);
        chk("arst_busy", 64'(bus16.busy), 64'd0);
        chk("arst_out_valid", 64'(bus16.out_valid), 64'd0);
        chk("arst_out_count", 64'(bus16.out_count), 64'd0);
        bus16.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 64'(bus16.busy), 64'd0);
        fill_ramp();
        run_job(26, 0, 0, 0);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
